// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock FIFO with count-decoded status flags, sticky
//               overflow/underflow and selectable registered or FWFT read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              halffull,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int              c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_CNT_FULL = (ADDR_W+1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_CNT_HALF = (ADDR_W+1)'(c_DEPTH / 2);
    localparam logic [ADDR_W:0] c_CNT_AF   = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] c_CNT_AE   = (ADDR_W+1)'(AE_LVL);
    localparam logic [ADDR_W:0] c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = (ADDR_W)'(1);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_ovf;
    logic              r_udf;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W-1:0] w_rptr_inc;

    // Flags come only from the registered count, so they lag the accepting edge by one cycle.
    assign empty        = (r_count == '0);
    assign full         = (r_count == c_CNT_FULL);
    assign halffull     = (r_count >= c_CNT_HALF);
    assign almost_full  = (r_count >= c_CNT_AF);
    assign almost_empty = (r_count <= c_CNT_AE);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
    assign data_out     = r_dout;

    assign w_rd_acc   = rd_en & ~empty;
    assign w_wr_acc   = wr_en & (~full | w_rd_acc);
    assign w_rptr_inc = r_rptr + c_PTR_ONE;

    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_rd_acc) r_rptr <= w_rptr_inc;
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // A new error in the same cycle as err_clr wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) r_ovf <= 1'b1;
            else if (err_clr)            r_ovf <= 1'b0;
            if (rd_en && empty)          r_udf <= 1'b1;
            else if (err_clr)            r_udf <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // r_dout always mirrors the head word while non-empty; it holds the last word once drained.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    if (r_count == c_CNT_ONE) begin
                        if (w_wr_acc) r_dout <= data_in;
                    end else begin
                        r_dout <= r_mem[w_rptr_inc];
                    end
                end else if (empty && w_wr_acc) begin
                    r_dout <= data_in;
                end
            end
        end else begin : g_reg_read
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[r_rptr];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter: DATA_W, default 8, data word width in bits.
REQ-002 Parameter: ADDR_W, default 4, address width; DEPTH = 2^ADDR_W words.
REQ-003 Parameter: AF_LVL, default 12, almost_full threshold in words (1..DEPTH-1).
REQ-004 Parameter: AE_LVL, default 2, almost_empty threshold in words (0..DEPTH-2).
REQ-005 Parameter: FWFT, default 0, read mode (0 = registered read, 1 = first-word-fall-through).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 rd_en  input  1  read request.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 err_clr  input  1  clears overflow/underflow when high.
REQ-012 data_out  output  DATA_W  read data.
REQ-013 empty  output  1  count == 0.
REQ-014 full  output  1  count == DEPTH.
REQ-015 halffull  output  1  count >= DEPTH/2.
REQ-016 almost_full  output  1  count >= AF_LVL.
REQ-017 almost_empty  output  1  count <= AE_LVL.
REQ-018 count  output  ADDR_W+1  current number of stored words.
REQ-019 overflow  output  1  sticky: write attempted while full and not accepted.
REQ-020 underflow  output  1  sticky: read attempted while empty.

Function
REQ-021 Storage shall be a DEPTH x DATA_W array with ADDR_W-bit write and read pointers wrapping from DEPTH-1 to 0.
REQ-022 Write accepted when wr_en=1 and (full=0 or read accepted same cycle); data_in stored at write pointer, pointer +1.
REQ-023 Read accepted when rd_en=1 and empty=0; read pointer +1.
REQ-024 count shall be registered: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
REQ-025 Full with wr_en=1 and rd_en=1: both accepted, count stays DEPTH, no overflow.
REQ-026 Empty with wr_en=1 and rd_en=1: write accepted, read rejected, underflow set, count becomes 1.
REQ-027 All status flags shall be decoded from the count register only, so they change one cycle after the accepting edge.
REQ-028 FWFT=0: on accepted read, data_out shall load the head word at that edge (1-cycle latency); otherwise data_out holds.
REQ-029 FWFT=1: data_out shall present the head word whenever empty=0 (visible the cycle after the write into an empty FIFO); accepted read advances to next word; value undefined-but-stable-hold of last word when empty.
REQ-030 overflow set on wr_en=1, full=1, rd_en=0; underflow set on rd_en=1, empty=1; both cleared by err_clr; set has priority over err_clr in the same cycle.
REQ-031 Data order shall be strictly first-in first-out across pointer wrap-around.

Reset
REQ-032 rst=1 at a clock edge shall force pointers=0, count=0, data_out=0, overflow=0, underflow=0; empty=1, almost_empty=1, full/halffull/almost_full=0.
REQ-033 rst mid-operation shall discard all stored words and override same-cycle wr_en/rd_en; memory contents need not be cleared.
REQ-034 First write/read is accepted on the edge after rst deasserts.

Verification (DATA_W=8, ADDR_W=4, AF_LVL=12, AE_LVL=2, FWFT=0 unless stated)
REQ-035 Reset, write 0x01..0x10 on 16 consecutive cycles -> almost_empty=0 after 3rd, halffull=1 after 8th, almost_full=1 after 12th, full=1 and count=16 after 16th.
REQ-036 From full, write 0x11 with rd_en=0 -> overflow=1, count=16; then read 16 -> data_out 0x01..0x10 in order, empty=1; 0x11 never appears.
REQ-037 Empty, rd_en=1 -> underflow=1, count=0, data_out unchanged; err_clr=1 one cycle -> underflow=0.
REQ-038 At count=5, wr_en=rd_en=1 for 20 cycles (crossing pointer wrap) -> count stays 5, output sequence equals input sequence delayed by 5 words; repeat at count=16 -> full stays 1, no overflow.
REQ-039 At count=9, assert rst one cycle with wr_en=1 -> next cycle count=0, empty=1; write 0xA5, read -> data_out=0xA5.
REQ-040 FWFT=1: write 0x3C into empty -> next cycle empty=0, data_out=0x3C without rd_en; rd_en=1 one cycle -> empty=1, count=0.
